// File: rtl/ft_tx_arbiter.sv
// Two-source round-robin packet arbiter feeding an FT2232 transmit byte stream; each packet is
// prefixed by a header byte (HDR_BASE | source id). Optional macro FT_TX_ARB_FLUSH_EN: out_done_o flush pulse.
module ft_tx_arbiter #(
  parameter logic [7:0] HDR_BASE = 8'hA0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        s0_req_i,
  input  logic [7:0]  s0_data_i,
  input  logic        s0_last_i,
  output logic        s0_ack_o,
  input  logic        s1_req_i,
  input  logic [7:0]  s1_data_i,
  input  logic        s1_last_i,
  output logic        s1_ack_o,
  output logic [7:0]  out_data_o,
  output logic        out_req_o,
  input  logic        out_ack_i,
  output logic        out_done_o,
  output logic [15:0] pkt_cnt0_o,
  output logic [15:0] pkt_cnt1_o
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;           // granted source id, held for the whole packet
  logic        last_gnt_q, last_gnt_d;
  logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [15:0] pkt_cnt1_q, pkt_cnt1_d;

  logic        src_req;
  logic        src_last;
  logic [7:0]  src_data;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    out_req_o  = 1'b0;
    out_data_o = 8'h00;
    s0_ack_o   = 1'b0;
    s1_ack_o   = 1'b0;

    src_req  = gnt_q ? s1_req_i  : s0_req_i;
    src_last = gnt_q ? s1_last_i : s0_last_i;
    src_data = gnt_q ? s1_data_i : s0_data_i;

    case (state_q)
      IDLE: begin
        if (s0_req_i && s1_req_i) begin
          gnt_d = ~last_gnt_q;
        end else begin
          gnt_d = s1_req_i;
        end
        if (s0_req_i || s1_req_i) begin
          state_d = HDR;
        end
      end

      HDR: begin
        out_req_o  = 1'b1;
        out_data_o = HDR_BASE | {7'b0, gnt_q};
        if (out_ack_i) begin
          state_d = DATA;
        end
      end

      DATA: begin
        // A source that drops its request stalls the stream; the grant is never abandoned.
        out_req_o  = src_req;
        out_data_o = src_data;
        if (src_req && out_ack_i) begin
          s0_ack_o = ~gnt_q;
          s1_ack_o = gnt_q;
          if (src_last) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (gnt_q) begin
          pkt_cnt1_d = pkt_cnt1_q + 16'd1;
        end else begin
          pkt_cnt0_d = pkt_cnt0_q + 16'd1;
        end
        last_gnt_d = gnt_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      pkt_cnt0_q <= 16'h0000;
      pkt_cnt1_q <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign pkt_cnt0_o = pkt_cnt0_q;
  assign pkt_cnt1_o = pkt_cnt1_q;

`ifdef FT_TX_ARB_FLUSH_EN
  assign out_done_o = (state_q == DONE) && !gnt_q;
`else
  assign out_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Directed self-checking bench for ft_tx_arbiter: queue-driven byte sources, a pulsing downstream
// acknowledge, and a monitor logging every transferred byte.
module tb_ft_tx_arbiter;

  logic        clk_i     = 1'b0;
  logic        reset_i   = 1'b1;
  logic        s0_req_i  = 1'b0;
  logic [7:0]  s0_data_i = 8'h00;
  logic        s0_last_i = 1'b0;
  logic        s0_ack_o;
  logic        s1_req_i  = 1'b0;
  logic [7:0]  s1_data_i = 8'h00;
  logic        s1_last_i = 1'b0;
  logic        s1_ack_o;
  logic [7:0]  out_data_o;
  logic        out_req_o;
  logic        out_ack_i = 1'b0;
  logic        out_done_o;
  logic [15:0] pkt_cnt0_o;
  logic [15:0] pkt_cnt1_o;

  ft_tx_arbiter dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .s0_req_i   (s0_req_i),
    .s0_data_i  (s0_data_i),
    .s0_last_i  (s0_last_i),
    .s0_ack_o   (s0_ack_o),
    .s1_req_i   (s1_req_i),
    .s1_data_i  (s1_data_i),
    .s1_last_i  (s1_last_i),
    .s1_ack_o   (s1_ack_o),
    .out_data_o (out_data_o),
    .out_req_o  (out_req_o),
    .out_ack_i  (out_ack_i),
    .out_done_o (out_done_o),
    .pkt_cnt0_o (pkt_cnt0_o),
    .pkt_cnt1_o (pkt_cnt1_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Source queues hold {last, data}; the head is presented until the source is acked.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] xlog[$];

  int ack_period  = 1;
  int ack_cyc     = 0;
  int s1_gap      = 0;
  bit s1_gap_arm  = 1'b0;
  int mon_cyc     = 0;
  int s0_acks     = 0;
  int s1_acks     = 0;
  int bad_ack     = 0;
  int done_cnt    = 0;
  int done_total  = 0;
  int done_cyc    = -1;
  int s0_last_cyc = -1;

  // Inputs change only on the falling edge.
  always @(negedge clk_i) begin
    ack_cyc++;
    out_ack_i = (ack_period <= 1) || (ack_cyc % ack_period == 0);
    if (q0.size() > 0) begin
      s0_req_i  = 1'b1;
      s0_data_i = q0[0][7:0];
      s0_last_i = q0[0][8];
    end else begin
      s0_req_i  = 1'b0;
      s0_data_i = 8'h00;
      s0_last_i = 1'b0;
    end
    if (s1_gap > 0) begin
      s1_req_i = 1'b0;
      s1_gap--;
    end else if (q1.size() > 0) begin
      s1_req_i  = 1'b1;
      s1_data_i = q1[0][7:0];
      s1_last_i = q1[0][8];
    end else begin
      s1_req_i  = 1'b0;
      s1_data_i = 8'h00;
      s1_last_i = 1'b0;
    end
  end

  // Monitor samples just before the rising edge, once inputs have settled.
  always @(negedge clk_i) begin
    #3;
    mon_cyc++;
    if (out_req_o && out_ack_i) xlog.push_back(out_data_o);
    if (s0_ack_o) begin
      s0_acks++;
      if (!(out_req_o && out_ack_i) || out_data_o !== s0_data_i || s1_ack_o) bad_ack++;
      if (s0_last_i) s0_last_cyc = mon_cyc;
      if (q0.size() > 0) void'(q0.pop_front());
    end
    if (s1_ack_o) begin
      s1_acks++;
      if (!(out_req_o && out_ack_i) || out_data_o !== s1_data_i) bad_ack++;
      if (s1_gap_arm) begin
        s1_gap     = 5;
        s1_gap_arm = 1'b0;
      end
      if (q1.size() > 0) void'(q1.pop_front());
    end
    if (out_done_o) begin
      done_cnt++;
      done_total++;
      done_cyc = mon_cyc;
    end
  end

  task automatic clear_logs();
    xlog.delete();
    s0_acks     = 0;
    s1_acks     = 0;
    bad_ack     = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    s0_last_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk_i); #4;
    reset_i = 1'b1;
    q0.delete();
    q1.delete();
    s1_gap     = 0;
    s1_gap_arm = 1'b0;
    repeat (2) @(negedge clk_i);
    #4;
    reset_i = 1'b0;
    clear_logs();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      @(negedge clk_i); #4;
      n++;
    end
    repeat (3) @(negedge clk_i);
    #4;
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s drain: sources still pending after %0d cycles (q0=%0d q1=%0d), required empty",
               name, n, q0.size(), q1.size());
    end
  endtask

  function automatic int first_diff(input logic [7:0] exp[$]);
    int n = (xlog.size() < exp.size()) ? xlog.size() : exp.size();
    for (int i = 0; i < n; i++) if (xlog[i] !== exp[i]) return i;
    if (xlog.size() != exp.size()) return n;
    return -1;
  endfunction

  task automatic report_stream(input string name, input int idx, input logic [7:0] exp[$]);
    logic [7:0] got_b = (idx < xlog.size()) ? xlog[idx] : 8'hxx;
    logic [7:0] exp_b = (idx < exp.size())  ? exp[idx]  : 8'hxx;
    $display("FAIL %s stream: byte %0d got %h required %h (got %0d bytes, required %0d)",
             name, idx, got_b, exp_b, xlog.size(), exp.size());
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    #4;
    checks++; if (out_req_o !== 1'b0)      begin errors++; $display("FAIL reset out_req: got %b required 0", out_req_o); end
    checks++; if (out_data_o !== 8'h00)    begin errors++; $display("FAIL reset out_data: got %h required 00", out_data_o); end
    checks++; if ({s0_ack_o, s1_ack_o} !== 2'b00) begin errors++; $display("FAIL reset acks: got %b%b required 00", s0_ack_o, s1_ack_o); end
    checks++; if (out_done_o !== 1'b0)     begin errors++; $display("FAIL reset out_done: got %b required 0", out_done_o); end
    checks++; if (pkt_cnt0_o !== 16'h0000) begin errors++; $display("FAIL reset pkt_cnt0: got %h required 0000", pkt_cnt0_o); end
    checks++; if (pkt_cnt1_o !== 16'h0000) begin errors++; $display("FAIL reset pkt_cnt1: got %h required 0000", pkt_cnt1_o); end
    reset_i = 1'b0;
    clear_logs();
  endtask

  task automatic test_single_packet();
    logic [7:0] exp[$];
    int d;
    do_reset();
    ack_period = 4;
    q0.push_back({1'b0, 8'h11});
    q0.push_back({1'b0, 8'h22});
    q0.push_back({1'b1, 8'h33});
    wait_drain("single", 200);
    exp = '{8'hA0, 8'h11, 8'h22, 8'h33};
    d = first_diff(exp);
    checks++; if (d >= 0) begin errors++; report_stream("single", d, exp); end
    checks++; if (s0_acks != 3) begin errors++; $display("FAIL single s0_acks: got %0d required 3", s0_acks); end
    checks++; if (s1_acks != 0) begin errors++; $display("FAIL single s1_acks: got %0d required 0", s1_acks); end
    checks++; if (pkt_cnt0_o !== 16'd1) begin errors++; $display("FAIL single pkt_cnt0: got %h required 0001", pkt_cnt0_o); end
    checks++; if (pkt_cnt1_o !== 16'd0) begin errors++; $display("FAIL single pkt_cnt1: got %h required 0000", pkt_cnt1_o); end
    checks++; if (bad_ack != 0) begin errors++; $display("FAIL single ack_integrity: got %0d bad pulses required 0", bad_ack); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp[$];
    int d;
    do_reset();
    ack_period = 1;
    for (int p = 0; p < 2; p++) begin
      q0.push_back({1'b0, 8'h01});
      q0.push_back({1'b1, 8'h02});
      q1.push_back({1'b0, 8'h81});
      q1.push_back({1'b1, 8'h82});
    end
    wait_drain("round_robin", 200);
    exp = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h81, 8'h82,
            8'hA0, 8'h01, 8'h02, 8'hA1, 8'h81, 8'h82};
    d = first_diff(exp);
    checks++; if (d >= 0) begin errors++; report_stream("round_robin", d, exp); end
    checks++; if (pkt_cnt0_o !== 16'd2 || pkt_cnt1_o !== 16'd2) begin
      errors++; $display("FAIL round_robin counts: got %h/%h required 0002/0002", pkt_cnt0_o, pkt_cnt1_o);
    end
    checks++; if (bad_ack != 0) begin errors++; $display("FAIL round_robin ack_integrity: got %0d bad pulses required 0", bad_ack); end
  endtask

  task automatic test_stall();
    logic [7:0] exp[$];
    int d;
    int n = 0;
    int stall_bad = 0;
    do_reset();
    ack_period = 1;
    s1_gap_arm = 1'b1;
    q1.push_back({1'b0, 8'h91});
    q1.push_back({1'b0, 8'h92});
    q1.push_back({1'b1, 8'h93});
    while (s1_acks < 1 && n < 50) begin
      @(negedge clk_i); #4;
      n++;
    end
    checks++; if (s1_acks < 1) begin errors++; $display("FAIL stall first_byte: got %0d s1 acks required 1", s1_acks); end
    q0.push_back({1'b1, 8'h44});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #4;
      if (out_req_o !== 1'b0) stall_bad++;
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall out_req: got %0d cycles high required 0", stall_bad); end
    checks++; if (s0_acks != 0) begin errors++; $display("FAIL stall s0_grant: got %0d s0 acks required 0", s0_acks); end
    wait_drain("stall", 200);
    exp = '{8'hA1, 8'h91, 8'h92, 8'h93, 8'hA0, 8'h44};
    d = first_diff(exp);
    checks++; if (d >= 0) begin errors++; report_stream("stall", d, exp); end
    checks++; if (pkt_cnt1_o !== 16'd1 || pkt_cnt0_o !== 16'd1) begin
      errors++; $display("FAIL stall counts: got %h/%h required 0001/0001", pkt_cnt0_o, pkt_cnt1_o);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] exp[$];
    int d;
    int n = 0;
    do_reset();
    ack_period = 1;
    q1.push_back({1'b0, 8'h55});
    q1.push_back({1'b0, 8'h66});
    q1.push_back({1'b1, 8'h77});
    while (s1_acks < 1 && n < 50) begin
      @(negedge clk_i); #4;
      n++;
    end
    reset_i = 1'b1;
    q1.delete();
    #1;
    checks++; if (out_req_o !== 1'b0 || out_data_o !== 8'h00 || s1_ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid outputs: got req=%b data=%h ack1=%b required 0/00/0", out_req_o, out_data_o, s1_ack_o);
    end
    checks++; if (pkt_cnt1_o !== 16'd0) begin errors++; $display("FAIL reset_mid pkt_cnt1: got %h required 0000", pkt_cnt1_o); end
    repeat (2) @(negedge clk_i);
    #4;
    reset_i = 1'b0;
    clear_logs();
    q1.push_back({1'b1, 8'h88});
    wait_drain("reset_mid", 100);
    exp = '{8'hA1, 8'h88};
    d = first_diff(exp);
    checks++; if (d >= 0) begin errors++; report_stream("reset_mid", d, exp); end
    checks++; if (pkt_cnt1_o !== 16'd1) begin errors++; $display("FAIL reset_mid pkt_cnt1_after: got %h required 0001", pkt_cnt1_o); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    ack_period = 1;
    @(negedge clk_i); #4;
    force dut.pkt_cnt1_q = 16'hFFFE;
    repeat (2) @(negedge clk_i);
    #4;
    release dut.pkt_cnt1_q;
    q1.push_back({1'b1, 8'hE1});
    wait_drain("wrap1", 100);
    checks++; if (pkt_cnt1_o !== 16'hFFFF) begin errors++; $display("FAIL wrap pkt_cnt1_full: got %h required ffff", pkt_cnt1_o); end
    q1.push_back({1'b1, 8'hE2});
    wait_drain("wrap2", 100);
    checks++; if (pkt_cnt1_o !== 16'h0000) begin errors++; $display("FAIL wrap pkt_cnt1_rollover: got %h required 0000", pkt_cnt1_o); end
    checks++; if (pkt_cnt0_o !== 16'h0000) begin errors++; $display("FAIL wrap pkt_cnt0: got %h required 0000", pkt_cnt0_o); end
  endtask

  task automatic test_flush();
    logic [7:0] exp[$];
    int d;
    do_reset();
    ack_period = 1;
    q0.push_back({1'b1, 8'hC1});
    q1.push_back({1'b1, 8'hD1});
    wait_drain("flush", 100);
    exp = '{8'hA0, 8'hC1, 8'hA1, 8'hD1};
    d = first_diff(exp);
    checks++; if (d >= 0) begin errors++; report_stream("flush", d, exp); end
`ifdef FT_TX_ARB_FLUSH_EN
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL flush done_cycles: got %0d required 1", done_cnt); end
    checks++; if (done_cyc != s0_last_cyc + 1) begin
      errors++; $display("FAIL flush done_timing: got cycle %0d required %0d", done_cyc, s0_last_cyc + 1);
    end
`else
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL flush done_cycles: got %0d required 0", done_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_stall();
    test_reset_mid_packet();
    test_counter_wrap();
    test_flush();
`ifndef FT_TX_ARB_FLUSH_EN
    checks++; if (done_total != 0) begin errors++; $display("FAIL done_never: got %0d high cycles required 0", done_total); end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ft_tx_arbiter.md
FT_TX_ARBITER -- requirements
Module: ft_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Ports, in order:
- clk_i  in  1  system clock
- reset_i  in  1  async active-high reset
- s0_req_i  in  1  source 0 (command replies) byte valid
- s0_data_i  in  8  source 0 byte
- s0_last_i  in  1  source 0 byte is last of packet
- s0_ack_o  out  1  source 0 byte consumed (1-cycle pulse)
- s1_req_i  in  1  source 1 (timetag events) byte valid
- s1_data_i  in  8  source 1 byte
- s1_last_i  in  1  source 1 byte is last of packet
- s1_ack_o  out  1  source 1 byte consumed (1-cycle pulse)
- out_data_o  out  8  byte to FT2232 interface
- out_req_o  out  1  byte valid to FT2232 interface
- out_ack_i  in  1  FT2232 interface took byte (1-cycle pulse)
- out_done_o  out  1  send-immediate request to FT2232 interface
- pkt_cnt0_o  out  16  packets completed from source 0
- pkt_cnt1_o  out  16  packets completed from source 1
REQ-003 Parameter: HDR_BASE, default 8'hA0, header byte base value; the source id is ORed into bit 0.

Function
REQ-004 Byte transfer downstream SHALL occur in any cycle where out_req_o=1 and out_ack_i=1; out_ack_i with out_req_o=0 SHALL be ignored.
REQ-005 States SHALL be IDLE, HDR, DATA, DONE.
REQ-006 IDLE: if any sN_req_i=1, grant one source and go to HDR next cycle; out_req_o=0.
REQ-007 Arbitration SHALL be round-robin: when both request, grant the source not granted last; after reset, source 0 has priority.
REQ-008 HDR: out_data_o=HDR_BASE|id, out_req_o=1; on transfer go to DATA.
REQ-009 DATA: out_data_o=granted sN_data_i, out_req_o=granted sN_req_i; on transfer pulse granted sN_ack_o in the same cycle; if sN_last_i=1 on that transfer go to DONE, else stay.
REQ-010 Grant SHALL be held for the whole packet; a source dropping sN_req_i mid-packet stalls DATA (out_req_o=0) and is never abandoned.
REQ-011 The non-granted sN_ack_o SHALL be 0 at all times.
REQ-012 DONE: increment the granted pkt_cntN_o by 1 modulo 2^16 (FFFF wraps to 0000), update last-grant, return to IDLE next cycle; out_req_o=0.
REQ-013 Minimum packet overhead SHALL be one header byte plus one DONE cycle plus one IDLE cycle; a one-byte packet is legal (first DATA byte has last=1).
REQ-014 If a request appears in DONE, it SHALL NOT be granted until the following IDLE cycle.

Reset
REQ-015 On reset_i=1, the block SHALL immediately go to IDLE, set last-grant to source 1 (so source 0 wins first), and drive out_req_o=0, out_data_o=0, s0_ack_o=0, s1_ack_o=0, out_done_o=0, pkt_cnt0_o=0, pkt_cnt1_o=0.
REQ-016 Reset mid-packet SHALL discard the packet with no counter increment; after release, arbitration restarts from IDLE.

Configuration
REQ-017 With macro FT_TX_ARB_FLUSH_EN defined, out_done_o SHALL pulse high for exactly the DONE cycle of each packet from source 0; source 1 packets SHALL NOT pulse it.
REQ-018 Without FT_TX_ARB_FLUSH_EN, out_done_o SHALL be constant 0.

Verification
REQ-019 After reset, s0 sends a 3-byte packet 11,22,33 (last on 33), out_ack_i pulsing every 4 cycles -> downstream A0,11,22,33; three s0_ack_o pulses; pkt_cnt0_o=1.
REQ-020 s0 and s1 both request continuously with 2-byte packets -> header sequence A0,A1,A0,A1; neither source's bytes are interleaved within a packet.
REQ-021 s1 drops s1_req_i for 5 cycles after its first data byte -> out_req_o=0 for those cycles; the packet resumes and completes; no s0 grant in between.
REQ-022 reset_i asserted during DATA of an s1 packet -> out_req_o=0 in the same cycle; pkt_cnt1_o=0; the next packet starts with a fresh header.
REQ-023 Preload by sending 65535 one-byte s1 packets, then send one more -> pkt_cnt1_o goes FFFF to 0000.
REQ-024 With FT_TX_ARB_FLUSH_EN, one s0 packet and one s1 packet -> exactly one single-cycle out_done_o pulse, in the s0 DONE cycle; without the macro -> out_done_o never 1.
